// File: rtl/pwm_capture.sv
// PWM receive path: measures period and high time of an external PWM input,
// recovers the generator duty word and flags a stuck input by timeout.
module pwm_capture #(
    parameter int PWM_INTERVAL   = 1200,
    parameter int TIMEOUT_CYCLES = 2400,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1),
    localparam int VW = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [VW-1:0] pwm_value,
    output logic [CW-1:0] high_cycles,
    output logic [CW-1:0] period_cycles,
    output logic          valid,
    output logic          stuck
);
    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] VALUE_LIM = CW'(PWM_INTERVAL - 1);
    localparam logic [VW-1:0] VALUE_MAX = VW'(PWM_INTERVAL - 1);

    state_t        state;
    logic          s1, s2, s3;
    logic [CW-1:0] period_cnt;
    logic [CW-1:0] high_cnt;
    logic          rise;
    logic          timeout;

    // The generator holds high for value+1 cycles, so h high cycles map to h-1.
    function automatic logic [VW-1:0] duty_from_high(input logic [CW-1:0] h);
        logic [CW-1:0] hm1;
        hm1 = h - CW'(1);
        if (h == '0)
            return '0;
        if (hm1 >= VALUE_LIM)
            return VALUE_MAX;
        return hm1[VW-1:0];
    endfunction

    assign rise    = s2 & ~s3;
    assign timeout = (period_cnt == TIMEOUT_C) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            state         <= IDLE;
            period_cnt    <= '0;
            high_cnt      <= '0;
            pwm_value     <= '0;
            high_cycles   <= '0;
            period_cycles <= '0;
            valid         <= 1'b0;
            stuck         <= 1'b0;
        end else begin
            // Synchronizer stage: only s2 feeds the measurement logic.
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;

            // Measurement stage: a rise always wins over a coincident timeout.
            if (rise) begin
                period_cnt <= CW'(1);
                high_cnt   <= CW'(1);
                if (state == MEAS) begin
                    period_cycles <= period_cnt;
                    high_cycles   <= high_cnt;
                    pwm_value     <= duty_from_high(high_cnt);
                    stuck         <= 1'b0;
                    valid         <= 1'b1;
                end
                state <= MEAS;
            end else if (timeout) begin
                stuck         <= 1'b1;
                period_cycles <= '0;
                high_cycles   <= s2 ? TIMEOUT_C : '0;
                pwm_value     <= s2 ? VALUE_MAX : '0;
                valid         <= 1'b1;
                state         <= IDLE;
                period_cnt    <= '0;
                high_cnt      <= '0;
            end else begin
                period_cnt <= period_cnt + CW'(1);
                if (s2)
                    high_cnt <= high_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture against an edge-indexed
// reference model of the capture and timeout rules.
module tb_pwm_capture;
    localparam int PI = 1200;
    localparam int TO = 2400;
    localparam int CW = 12;
    localparam int VW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [VW-1:0] pwm_value;
    logic [CW-1:0] high_cycles;
    logic [CW-1:0] period_cycles;
    logic          valid;
    logic          stuck;

    int checks = 0;
    int failures = 0;

    // Reference model state, indexed by clock edge since reset release.
    int n, ref_edge, last_rise, high_sum;
    bit ref_rise, meas, d1, d2, px;
    logic          e_valid, e_stuck;
    logic [VW-1:0] e_value;
    logic [CW-1:0] e_high, e_period;

    wire [36:0] obs  = {valid, stuck, pwm_value, high_cycles, period_cycles};
    wire [36:0] expv = {e_valid, e_stuck, e_value, e_high, e_period};

    pwm_capture #(.PWM_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .pwm_value(pwm_value),
        .high_cycles(high_cycles), .period_cycles(period_cycles),
        .valid(valid), .stuck(stuck)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        n = 0; ref_edge = 0; ref_rise = 0; last_rise = 0; high_sum = 0;
        meas = 0; d1 = 0; d2 = 0; px = 0;
        e_valid = 0; e_stuck = 0; e_value = '0; e_high = '0; e_period = '0;
    endtask

    // The input driven before edge n-2 is what the measurement sees at edge n.
    task automatic model_edge(input bit v);
        bit x, r;
        int elapsed, h;
        n++;
        x = d2;
        r = x && !px;
        elapsed = ref_rise ? (n - ref_edge) : (n - 1 - ref_edge);
        e_valid = 1'b0;
        if (r) begin
            if (meas) begin
                h = high_sum - 1;
                if (h > PI - 1) h = PI - 1;
                e_valid = 1'b1; e_stuck = 1'b0;
                e_period = CW'(n - last_rise); e_high = CW'(high_sum); e_value = VW'(h);
            end
            meas = 1; last_rise = n; ref_edge = n; ref_rise = 1; high_sum = 1;
        end else if (elapsed == TO) begin
            e_valid = 1'b1; e_stuck = 1'b1; e_period = '0;
            e_high  = x ? CW'(TO) : '0;
            e_value = x ? VW'(PI - 1) : '0;
            meas = 0; ref_edge = n; ref_rise = 0; high_sum = 0;
        end else if (x) begin
            high_sum++;
        end
        px = x; d2 = d1; d1 = v;
    endtask

    task automatic tick(input bit v);
        pwm_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL reset_state got=%h want=0", obs); end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL reset_idle n=%0d got=%h want=%h", n, obs, expv); end
        end
    endtask

    task automatic test_steady();
        int nv = 0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 1200; c++) begin
                tick(c < 601);
                if (valid) nv++;
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL steady n=%0d got=%h want=%h", n, obs, expv); end
            end
        checks++;
        if (nv != 3) begin failures++; $display("FAIL steady_valids got=%0d want=3", nv); end
        checks++;
        if (period_cycles !== 12'd1200 || high_cycles !== 12'd601 || pwm_value !== 11'd600 || stuck !== 1'b0) begin
            failures++;
            $display("FAIL steady_final got p=%0d h=%0d v=%0d s=%0d want 1200 601 600 0", period_cycles, high_cycles, pwm_value, stuck);
        end
    endtask

    task automatic test_duty_change();
        int nv = 0;
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 1200; c++) begin
                tick(c < 101);
                if (valid) nv++;
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL duty n=%0d got=%h want=%h", n, obs, expv); end
                if (p == 0 && c == 1) begin
                    checks++;
                    if (pwm_value !== 11'd600) begin failures++; $display("FAIL duty_hold got=%0d want=600", pwm_value); end
                end
            end
        checks++;
        if (nv != 3 || high_cycles !== 12'd101 || pwm_value !== 11'd100) begin
            failures++;
            $display("FAIL duty_final got nv=%0d h=%0d v=%0d want 3 101 100", nv, high_cycles, pwm_value);
        end
    endtask

    task automatic test_stuck_high();
        int nv = 0;
        for (int c = 0; c < 2600; c++) begin
            tick(1'b1);
            if (valid) nv++;
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL stuck_high n=%0d got=%h want=%h", n, obs, expv); end
        end
        checks++;
        if (nv != 2 || stuck !== 1'b1 || pwm_value !== 11'd1199 || high_cycles !== 12'd2400 || period_cycles !== 12'd0) begin
            failures++;
            $display("FAIL stuck_high_final got nv=%0d s=%0d v=%0d h=%0d p=%0d want 2 1 1199 2400 0",
                     nv, stuck, pwm_value, high_cycles, period_cycles);
        end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 1200; c++) begin
                tick(c < 601);
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL resume n=%0d got=%h want=%h", n, obs, expv); end
            end
            if (p == 1) begin
                checks++;
                if (stuck !== 1'b1) begin failures++; $display("FAIL resume_first_rise stuck=%0d want=1", stuck); end
            end
        end
        checks++;
        if (stuck !== 1'b0 || period_cycles !== 12'd1200 || pwm_value !== 11'd600) begin
            failures++;
            $display("FAIL resume_final got s=%0d p=%0d v=%0d want 0 1200 600", stuck, period_cycles, pwm_value);
        end
    endtask

    task automatic test_stuck_low();
        int nv = 0;
        apply_reset();
        for (int c = 0; c < 5000; c++) begin
            tick(1'b0);
            if (valid) begin
                nv++;
                checks++;
                if (stuck !== 1'b1 || pwm_value !== 11'd0 || high_cycles !== 12'd0 || period_cycles !== 12'd0) begin
                    failures++;
                    $display("FAIL stuck_low_vals got s=%0d v=%0d h=%0d p=%0d want 1 0 0 0", stuck, pwm_value, high_cycles, period_cycles);
                end
            end
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL stuck_low n=%0d got=%h want=%h", n, obs, expv); end
        end
        checks++;
        if (nv != 2) begin failures++; $display("FAIL stuck_low_valids got=%0d want=2", nv); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        for (int c = 0; c < 1700; c++) begin
            tick((c % 1200) < 601);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL pre_reset n=%0d got=%h want=%h", n, obs, expv); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL async_reset got=%h want=0", obs); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 1200; c++) begin
                tick(c < 601);
                if (valid) nv++;
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL post_reset n=%0d got=%h want=%h", n, obs, expv); end
            end
        checks++;
        if (nv != 2 || period_cycles !== 12'd1200 || high_cycles !== 12'd601 || pwm_value !== 11'd600) begin
            failures++;
            $display("FAIL post_reset_final got nv=%0d p=%0d h=%0d v=%0d want 2 1200 601 600", nv, period_cycles, high_cycles, pwm_value);
        end
    endtask

    task automatic test_coincident();
        int nstuck = 0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 2400; c++) begin
                tick(c < 300);
                if (valid && stuck) nstuck++;
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL coincident n=%0d got=%h want=%h", n, obs, expv); end
            end
        checks++;
        if (nstuck != 0 || stuck !== 1'b0 || period_cycles !== 12'd2400 || high_cycles !== 12'd300 || pwm_value !== 11'd299) begin
            failures++;
            $display("FAIL coincident_final got ns=%0d s=%0d p=%0d h=%0d v=%0d want 0 0 2400 300 299",
                     nstuck, stuck, period_cycles, high_cycles, pwm_value);
        end
    endtask

    task automatic test_clamp();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 2000; c++) begin
                tick(c < 1800);
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL clamp n=%0d got=%h want=%h", n, obs, expv); end
            end
        checks++;
        if (pwm_value !== 11'd1199 || high_cycles !== 12'd1800 || period_cycles !== 12'd2000) begin
            failures++;
            $display("FAIL clamp_final got v=%0d h=%0d p=%0d want 1199 1800 2000", pwm_value, high_cycles, period_cycles);
        end
    endtask

    task automatic test_random();
        int per, hi, len;
        bit lvl;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                len = $urandom_range(2500, 3000);
                lvl = 1'($urandom_range(0, 1));
                for (int c = 0; c < len; c++) begin
                    tick(lvl);
                    checks++;
                    if (obs !== expv) begin failures++; $display("FAIL random_hold n=%0d got=%h want=%h", n, obs, expv); end
                end
            end else begin
                per = $urandom_range(20, 2300);
                hi  = $urandom_range(1, per - 1);
                for (int c = 0; c < per; c++) begin
                    tick(c < hi);
                    checks++;
                    if (obs !== expv) begin failures++; $display("FAIL random_pwm n=%0d got=%h want=%h", n, obs, expv); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_duty_change();
        test_stuck_high();
        test_stuck_low();
        test_reset_mid();
        test_coincident();
        test_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive side of the LED PWM path. Samples an external PWM waveform and measures its period and high time in clk cycles.
- Recovers the duty word that the on-chip PWM generator would have needed to produce that waveform.
- Used for loopback self-test and for reading duty from external PWM sources.
- Detects a stuck-low or stuck-high input by timeout.

Parameters:
- PWM_INTERVAL, 1200, nominal PWM period in clk cycles (100us at 12MHz); sets pwm_value width and clamp.
- TIMEOUT_CYCLES, 2400, cycles without a rising edge before the input is declared stuck; must be > PWM_INTERVAL.
- CW (localparam), $clog2(TIMEOUT_CYCLES+1), width of the cycle counters.

Ports:
- clk, input, 1, system clock (12MHz).
- rst_n, input, 1, reset. Asynchronous and active-low.
- pwm_in, input, 1, asynchronous PWM waveform.
- pwm_value, output, $clog2(PWM_INTERVAL), recovered duty word.
- high_cycles, output, CW, high time of the last complete period.
- period_cycles, output, CW, rising-to-rising period of the last complete period.
- valid, output, 1, one-cycle pulse when the outputs update.
- stuck, output, 1, high while the input has had no rising edge for TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync release):
  - sync flops, counters and all outputs = 0.
  - FSM = IDLE.
- Input conditioning:
  - pwm_in passes through 2 flops to give s2; s3 = previous s2.
  - rise = s2 & ~s3.
  - Only s2 is used downstream.
- FSM states:
  - IDLE: no period reference yet. First rise moves to MEAS; nothing is captured.
  - MEAS: counting. Each rise captures the period and stays in MEAS.
- Counters:
  - On any rise, period_cnt and high_cnt load 1.
  - On every other cycle, period_cnt increments, and high_cnt increments when s2 = 1.
  - In IDLE, period_cnt counts idle cycles for the timeout.
- Capture (on a rise while in MEAS, registered):
  - period_cycles <= period_cnt.
  - high_cycles <= high_cnt.
  - pwm_value <= min(high_cnt-1, PWM_INTERVAL-1).
  - stuck <= 0.
  - valid = 1 for exactly the next cycle.
- Mapping:
  - The generator holds output high for value+1 cycles when value > 0.
  - A capture of high h therefore yields value h-1.
- Timeout: when period_cnt reaches TIMEOUT_CYCLES with no rise in that cycle (either state):
  - stuck <= 1; period_cycles <= 0.
  - high_cycles <= 0 if s2 = 0, else TIMEOUT_CYCLES.
  - pwm_value <= 0 if s2 = 0, else PWM_INTERVAL-1.
  - valid pulses; FSM -> IDLE; period_cnt and high_cnt reload 0.
  - The timeout therefore repeats every TIMEOUT_CYCLES while the input stays stuck.
- Simultaneous rise and timeout in the same cycle: rise wins; no timeout is taken.
- Latency: pwm_in first sampled high at edge k gives capture at edge k+2 and valid high during the cycle after edge k+2.
- Outputs hold their value between updates; valid is never high for two consecutive cycles.
- Reset mid-period: the partial measurement is discarded, outputs clear, and the next period needs two rises.
- Pulses shorter than one clk period may be missed; no glitch filtering is required.
- Counters never exceed TIMEOUT_CYCLES, so no wrap-around is possible.

Test Plan:
- Reset then continuous PWM, period 1200, high 601 cycles -> no valid on the first rise; every later rise gives valid, period_cycles = 1200, high_cycles = 601, pwm_value = 600, stuck = 0.
- Duty changes from 601 to 101 high cycles mid-stream -> the next capture is high_cycles = 101 and pwm_value = 100; the previous value is held until then.
- pwm_in held low after reset -> valid at 2400 cycles after reset and every 2400 cycles thereafter; each time stuck = 1, pwm_value = 0, high_cycles = 0, period_cycles = 0.
- Running PWM, then pwm_in held high -> after 2400 cycles without a rise: stuck = 1, pwm_value = 1199, high_cycles = 2400. PWM then resumes -> stuck clears on the second rise, with a valid capture.
- rst_n asserted at cycle 500 of a period -> all outputs 0 immediately (async); after release, the first capture occurs at the second rise and carries correct values.
- Rise coinciding with period_cnt = TIMEOUT_CYCLES (period 2400) -> a normal capture with period_cycles = 2400 and stuck = 0; no timeout pulse.
